// File: rtl/bdb_pkg.sv
// Shared types and default constants for the debounced press counter.
package bdb_pkg;

    // Debounce FSM states; the encoding is visible on the state_dbg port.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } bdb_state_e;

    localparam int BDB_DEBOUNCE_CYCLES = 4;
    localparam int BDB_COUNT_WIDTH     = 8;

endpackage

// File: rtl/bdb_synchronizer.sv
// Two-flop synchronizer bringing the raw button level into the clock domain.
module bdb_synchronizer (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops; both clear on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bdb_debounced_counter.sv
// Debounces a push-button and counts accepted presses.
// The FSM only ever sees the synchronized level btn_s. A press is accepted
// once btn_s has been high for DEBOUNCE_CYCLES consecutive samples; a release
// needs the same stability before the FSM can accept another press, so a
// glitch low during a held press returns to PRESSED without counting again.
module bdb_debounced_counter
    import bdb_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BDB_DEBOUNCE_CYCLES,
    parameter int COUNT_WIDTH     = BDB_COUNT_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   button,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   press_pulse,
    output logic                   debounced,
    output logic                   wrap_pulse,
    output bdb_state_e             state_dbg
);

    localparam int SW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_TARGET = SW'(DEBOUNCE_CYCLES);

    logic       btn_s;
    bdb_state_e state;
    bdb_state_e state_next;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_next;
    logic [SW-1:0] stable_inc;
    logic       accept;

    bdb_synchronizer u_sync (
        .clock (clock),
        .reset (reset),
        .d     (button),
        .q     (btn_s)
    );

    assign stable_inc = stable_cnt + SW'(1);

    // State register together with the stability counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            stable_cnt <= '0;
        end else begin
            state      <= state_next;
            stable_cnt <= stable_next;
        end
    end

    // Next-state logic; accept marks the PRESS_WAIT -> PRESSED transition.
    always_comb begin
        state_next  = state;
        stable_next = stable_cnt;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next  = PRESS_WAIT;
                    stable_next = SW'(1);
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    if (stable_inc == STABLE_TARGET) begin
                        state_next  = PRESSED;
                        stable_next = '0;
                        accept      = 1'b1;
                    end else begin
                        stable_next = stable_inc;
                    end
                end else begin
                    state_next  = IDLE;
                    stable_next = '0;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_next  = RELEASE_WAIT;
                    stable_next = SW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (!btn_s) begin
                    if (stable_inc == STABLE_TARGET) begin
                        state_next  = IDLE;
                        stable_next = '0;
                    end else begin
                        stable_next = stable_inc;
                    end
                end else begin
                    // Glitch during a held press: back to PRESSED, no new count.
                    state_next  = PRESSED;
                    stable_next = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                stable_next = '0;
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        debounced = (state == PRESSED) || (state == RELEASE_WAIT);
        state_dbg = state;
    end

    // Press counter and strobes; clear wins over the increment and hides the wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count       <= '0;
            press_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
        end else begin
            press_pulse <= accept;
            wrap_pulse  <= accept && !clear && (count == {COUNT_WIDTH{1'b1}});
            if (clear) begin
                count <= '0;
            end else if (accept) begin
                count <= count + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_bdb_debounced_counter.sv
// Directed bench for bdb_debounced_counter with default parameters (D=4, W=8).
module tb_bdb_debounced_counter;
    import bdb_pkg::*;

    logic       clock;
    logic       reset;
    logic       button;
    logic       clear;
    logic [7:0] count;
    logic       press_pulse;
    logic       debounced;
    logic       wrap_pulse;
    bdb_state_e state_dbg;

    int total = 0;
    int bad   = 0;
    int pulse_seen = 0;
    int wrap_seen  = 0;

    bdb_debounced_counter dut (
        .clock       (clock),
        .reset       (reset),
        .button      (button),
        .clear       (clear),
        .count       (count),
        .press_pulse (press_pulse),
        .debounced   (debounced),
        .wrap_pulse  (wrap_pulse),
        .state_dbg   (state_dbg)
    );

    // Clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobe monitors sample away from the active edge.
    always @(negedge clock) begin
        if (press_pulse === 1'b1) pulse_seen++;
        if (wrap_pulse === 1'b1) wrap_seen++;
    end

    // Advance one rising edge and settle.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Driver: one full accepted press and clean release (no checks).
    task automatic drive_press();
        button = 1'b1;
        tick(8);
        button = 1'b0;
        tick(8);
    endtask

    task automatic test_reset();
        reset = 1'b0; button = 1'b0; clear = 1'b0;
        tick(3);
        total++;
        if (count !== 8'd0 || press_pulse !== 1'b0 || wrap_pulse !== 1'b0 ||
            debounced !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state: count=%0d pp=%b wp=%b deb=%b st=%0d, need 0/0/0/0/IDLE",
                     count, press_pulse, wrap_pulse, debounced, state_dbg);
        end
        reset = 1'b1;
        tick(2);
    endtask

    task automatic test_press();
        int p0;
        p0 = pulse_seen;
        button = 1'b1;
        tick(5);
        total++;
        if (count !== 8'd0 || press_pulse !== 1'b0) begin
            bad++;
            $display("FAIL press_edge5: count=%0d pp=%b, need 0/0", count, press_pulse);
        end
        tick(1);
        total++;
        if (count !== 8'd1 || press_pulse !== 1'b1 || debounced !== 1'b1 || state_dbg !== PRESSED) begin
            bad++;
            $display("FAIL press_edge6: count=%0d pp=%b deb=%b st=%0d, need 1/1/1/PRESSED",
                     count, press_pulse, debounced, state_dbg);
        end
        tick(1);
        total++;
        if (press_pulse !== 1'b0) begin
            bad++;
            $display("FAIL press_one_cycle: pp=%b, need 0", press_pulse);
        end
        tick(12);
        total++;
        if (count !== 8'd1 || pulse_seen - p0 !== 1) begin
            bad++;
            $display("FAIL long_hold: count=%0d pulses=%0d, need 1/1", count, pulse_seen - p0);
        end
        button = 1'b0;
        tick(5);
        total++;
        if (debounced !== 1'b1 || state_dbg !== RELEASE_WAIT) begin
            bad++;
            $display("FAIL release_edge5: deb=%b st=%0d, need 1/RELEASE_WAIT", debounced, state_dbg);
        end
        tick(1);
        total++;
        if (debounced !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL release_edge6: deb=%b st=%0d, need 0/IDLE", debounced, state_dbg);
        end
        tick(4);
    endtask

    task automatic test_bounce();
        int p0;
        int deb_hi;
        p0 = pulse_seen;
        deb_hi = 0;
        button = 1'b1;
        tick(3);
        button = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (debounced !== 1'b0) deb_hi++;
        end
        total++;
        if (count !== 8'd1 || pulse_seen - p0 !== 0 || deb_hi !== 0) begin
            bad++;
            $display("FAIL short_bounce: count=%0d pulses=%0d deb_hi=%0d, need 1/0/0",
                     count, pulse_seen - p0, deb_hi);
        end
    endtask

    task automatic test_glitch();
        int p0;
        int deb_lo;
        p0 = pulse_seen;
        deb_lo = 0;
        button = 1'b1;
        tick(6);
        tick(4);
        button = 1'b0;
        tick(2);
        button = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (debounced !== 1'b1) deb_lo++;
        end
        total++;
        if (deb_lo !== 0) begin
            bad++;
            $display("FAIL glitch_debounced: low_cycles=%0d, need 0", deb_lo);
        end
        button = 1'b0;
        tick(10);
        total++;
        if (count !== 8'd2 || pulse_seen - p0 !== 1 || debounced !== 1'b0) begin
            bad++;
            $display("FAIL glitch_count: count=%0d pulses=%0d deb=%b, need 2/1/0",
                     count, pulse_seen - p0, debounced);
        end
    endtask

    task automatic test_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        total++;
        if (count !== 8'd0) begin
            bad++;
            $display("FAIL clear_plain: count=%0d, need 0", count);
        end
        drive_press();
        total++;
        if (count !== 8'd1) begin
            bad++;
            $display("FAIL clear_then_press: count=%0d, need 1", count);
        end
        button = 1'b1;
        tick(5);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        total++;
        if (count !== 8'd0 || press_pulse !== 1'b1 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL clear_with_press: count=%0d pp=%b wp=%b, need 0/1/0",
                     count, press_pulse, wrap_pulse);
        end
        tick(3);
        button = 1'b0;
        tick(8);
    endtask

    task automatic test_wrap();
        int w0;
        w0 = wrap_seen;
        for (int i = 0; i < 255; i++) drive_press();
        total++;
        if (count !== 8'd255 || wrap_seen - w0 !== 0) begin
            bad++;
            $display("FAIL preload_255: count=%0d wraps=%0d, need 255/0", count, wrap_seen - w0);
        end
        button = 1'b1;
        tick(6);
        total++;
        if (count !== 8'd0 || wrap_pulse !== 1'b1 || press_pulse !== 1'b1) begin
            bad++;
            $display("FAIL wrap_edge: count=%0d wp=%b pp=%b, need 0/1/1", count, wrap_pulse, press_pulse);
        end
        tick(1);
        total++;
        if (wrap_pulse !== 1'b0 || wrap_seen - w0 !== 1) begin
            bad++;
            $display("FAIL wrap_one_cycle: wp=%b wraps=%0d, need 0/1", wrap_pulse, wrap_seen - w0);
        end
        button = 1'b0;
        tick(8);
    endtask

    task automatic test_reset_mid_press();
        drive_press();
        button = 1'b1;
        tick(8);
        total++;
        if (count !== 8'd2 || state_dbg !== PRESSED) begin
            bad++;
            $display("FAIL pre_reset: count=%0d st=%0d, need 2/PRESSED", count, state_dbg);
        end
        reset = 1'b0;
        #1;
        total++;
        if (count !== 8'd0 || debounced !== 1'b0 || press_pulse !== 1'b0 ||
            wrap_pulse !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL async_reset: count=%0d deb=%b pp=%b wp=%b st=%0d, need 0/0/0/0/IDLE",
                     count, debounced, press_pulse, wrap_pulse, state_dbg);
        end
        tick(2);
        reset = 1'b1;
        tick(5);
        total++;
        if (count !== 8'd0 || debounced !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_edge5: count=%0d deb=%b, need 0/0", count, debounced);
        end
        tick(1);
        total++;
        if (count !== 8'd1 || press_pulse !== 1'b1 || debounced !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_edge6: count=%0d pp=%b deb=%b, need 1/1/1",
                     count, press_pulse, debounced);
        end
        button = 1'b0;
        tick(8);
    endtask

    initial begin
        test_reset();
        test_press();
        test_bounce();
        test_glitch();
        test_clear();
        test_wrap();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
